// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the two-channel framed-packet arbiter pair (TX mux / RX demux).
// Header word: SELMASK bit picks the channel, CNTMASK field >> CNTSHIFT gives payload count - 1.
package fifo_arb_pkg;

  localparam int unsigned DEF_DWIDTH   = 8;
  localparam logic [7:0]  DEF_SELMASK  = 8'h80;
  localparam logic [7:0]  DEF_CNTMASK  = 8'h70;
  localparam int unsigned DEF_CNTSHIFT = 4;

  typedef enum logic [1:0] {
    R_HDR   = 2'd0,
    R_HWAIT = 2'd1,
    R_DATA  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_arb_rx.sv
// RX demux: drains one framed input FIFO, drops each header and steers the payload
// to channel 1 or 2, with a one-word skid for a target full flag that lags our writes.
module fifo_arb_rx
  import fifo_arb_pkg::*;
#(
  parameter int unsigned       DWIDTH   = DEF_DWIDTH,
  parameter logic [DWIDTH-1:0] SELMASK  = DWIDTH'(DEF_SELMASK),
  parameter logic [DWIDTH-1:0] CNTMASK  = DWIDTH'(DEF_CNTMASK),
  parameter int unsigned       CNTSHIFT = DEF_CNTSHIFT
) (
  input  logic              CLK,
  input  logic              RESETn,
  output logic              fifo_rden,
  input  logic              fifo_rdempty,
  input  logic [DWIDTH-1:0] fifo_rddata,
  output logic              c1_wren,
  input  logic              c1_wrfull,
  output logic [DWIDTH-1:0] c1_wrdata,
  output logic              c2_wren,
  input  logic              c2_wrfull,
  output logic [DWIDTH-1:0] c2_wrdata
);

  localparam int unsigned CNT_W = DWIDTH + 1;

  rd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_sel_q, rd_sel_d;
  logic              skid_valid_q, skid_valid_d;
  logic              skid_sel_q, skid_sel_d;
  logic [DWIDTH-1:0] skid_data_q, skid_data_d;
  logic              en_q, en_d;

  logic              sel_full, ret_full, skid_full;
  logic              wr_en, wr_sel;
  logic [DWIDTH-1:0] wr_data;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    rd_pend_d    = 1'b0;
    rd_sel_d     = rd_sel_q;
    skid_valid_d = skid_valid_q;
    skid_sel_d   = skid_sel_q;
    skid_data_d  = skid_data_q;
    en_d         = 1'b1;
    fifo_rden    = 1'b0;
    wr_en        = 1'b0;
    wr_sel       = 1'b0;
    wr_data      = '0;

    sel_full  = sel_q      ? c2_wrfull : c1_wrfull;
    ret_full  = rd_sel_q   ? c2_wrfull : c1_wrfull;
    skid_full = skid_sel_q ? c2_wrfull : c1_wrfull;

    // A returning payload word and a held skid word never coexist: reads stop while skid is valid.
    if (rd_pend_q) begin
      if (!ret_full) begin
        wr_en   = 1'b1;
        wr_sel  = rd_sel_q;
        wr_data = fifo_rddata;
      end else begin
        skid_valid_d = 1'b1;
        skid_sel_d   = rd_sel_q;
        skid_data_d  = fifo_rddata;
      end
    end else if (skid_valid_q && !skid_full) begin
      wr_en        = 1'b1;
      wr_sel       = skid_sel_q;
      wr_data      = skid_data_q;
      skid_valid_d = 1'b0;
    end

    case (state_q)
      R_HDR: begin
        if (en_q && !fifo_rdempty && !skid_valid_q) begin
          fifo_rden = 1'b1;
          state_d   = R_HWAIT;
        end
      end
      R_HWAIT: begin
        sel_d   = |(fifo_rddata & SELMASK);
        cnt_d   = CNT_W'((fifo_rddata & CNTMASK) >> CNTSHIFT) + CNT_W'(1);
        state_d = R_DATA;
      end
      R_DATA: begin
        if (!fifo_rdempty && !skid_valid_q && !sel_full) begin
          fifo_rden = 1'b1;
          rd_pend_d = 1'b1;
          rd_sel_d  = sel_q;
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = R_HDR;
        end
      end
      default: state_d = R_HDR;
    endcase

    c1_wren   = wr_en & ~wr_sel;
    c2_wren   = wr_en &  wr_sel;
    c1_wrdata = c1_wren ? wr_data : '0;
    c2_wrdata = c2_wren ? wr_data : '0;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= R_HDR;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_sel_q     <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_sel_q   <= 1'b0;
      skid_data_q  <= '0;
      en_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      rd_pend_q    <= rd_pend_d;
      rd_sel_q     <= rd_sel_d;
      skid_valid_q <= skid_valid_d;
      skid_sel_q   <= skid_sel_d;
      skid_data_q  <= skid_data_d;
      en_q         <= en_d;
    end
  end

endmodule
